// File: rtl/vctr_fifo_driver.sv
// vctr_fifo_driver: streams two host-loaded vectors into the vector FIFO compute block
// and drains its result vector into a host-readable buffer. Watchdog option: VCTR_DRV_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for go while the block reports idle; host may write vectors
// START     | acc_start held until the block reports ready
// SEND      | one beat per ready cycle, vec1 then vec2 (2N beats)
// WAIT_DONE | waiting for the block to report done
// DRAIN     | N read strobes, each word captured one cycle later
// FINISH    | one-cycle complete pulse
module vctr_fifo_driver #(
  parameter int WORD_WIDTH      = 16,
  parameter int HSP_BANDS_WIDTH = 3,
  parameter int TIMEOUT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       host_wr_en,
  input  logic                       host_wr_sel,
  input  logic [HSP_BANDS_WIDTH-1:0] host_wr_addr,
  input  logic [WORD_WIDTH-1:0]      host_wr_data,
  input  logic [HSP_BANDS_WIDTH-1:0] host_rd_addr,
  output logic [WORD_WIDTH-1:0]      host_rd_data,
  input  logic                       go,
  output logic                       busy,
  output logic                       complete,
  output logic                       error,
  output logic                       acc_start,
  output logic                       acc_data_in_en,
  output logic [WORD_WIDTH-1:0]      acc_data_in,
  output logic                       acc_data_out_en,
  input  logic [WORD_WIDTH-1:0]      acc_data_out,
  input  logic                       acc_idle,
  input  logic                       acc_ready,
  input  logic                       acc_done
);

  localparam int N  = 1 << HSP_BANDS_WIDTH;
  localparam int CW = HSP_BANDS_WIDTH + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(2 * N - 1);
  localparam logic [CW-1:0] NUM_READS = CW'(N);

  typedef enum logic [2:0] {IDLE, START, SEND, WAIT_DONE, DRAIN, FINISH} state_t;

  state_t state, state_next;

  logic [WORD_WIDTH-1:0]      vec1   [N];
  logic [WORD_WIDTH-1:0]      vec2   [N];
  logic [WORD_WIDTH-1:0]      result [N];
  logic [CW-1:0]              beat_cnt;
  logic [CW-1:0]              read_cnt;
  logic                       cap_valid;
  logic [HSP_BANDS_WIDTH-1:0] cap_idx;
  logic [HSP_BANDS_WIDTH-1:0] beat_idx;
  logic                       go_ok;
  logic                       timeout;

  assign go_ok    = (state == IDLE) && go && acc_idle;
  assign busy     = (state != IDLE);
  assign beat_idx = beat_cnt[HSP_BANDS_WIDTH-1:0];

  // beat_cnt MSB selects vec2 for the second half of the stream
  assign acc_data_in  = (state == SEND) ? (beat_cnt[HSP_BANDS_WIDTH] ? vec2[beat_idx] : vec1[beat_idx])
                                        : '0;
  assign host_rd_data = result[host_rd_addr];

`ifdef VCTR_DRV_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] wd_cnt;
  logic                     error_q;
  logic                     waiting;

  assign waiting = (state == START) || (state == WAIT_DONE);
  assign timeout = waiting && (wd_cnt == TIMEOUT_WIDTH'(1));
  assign error   = error_q;

  // down-counter reloaded on every state change; terminal count = all-ones cycles waited
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      if (state_next != state) wd_cnt <= '1;
      else if (waiting)        wd_cnt <= wd_cnt - 1'b1;
      if (go_ok)               error_q <= 1'b0;
      else if (timeout)        error_q <= 1'b1;
    end
  end
`else
  logic [TIMEOUT_WIDTH-1:0] unused_wd;
  assign unused_wd = '0;
  assign timeout   = 1'b0;
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next      = state;
    acc_start       = 1'b0;
    acc_data_in_en  = 1'b0;
    acc_data_out_en = 1'b0;
    complete        = 1'b0;
    case (state)
      IDLE:      if (go_ok) state_next = START;
      START: begin
        acc_start = 1'b1;
        if (acc_ready)    state_next = SEND;
        else if (timeout) state_next = IDLE;
      end
      SEND: begin
        acc_data_in_en = acc_ready;
        if (acc_ready && (beat_cnt == LAST_BEAT)) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (acc_done)     state_next = DRAIN;
        else if (timeout) state_next = IDLE;
      end
      DRAIN: begin
        // strobes stop at N; the extra cycle covers the last capture
        acc_data_out_en = (read_cnt != NUM_READS);
        if (read_cnt == NUM_READS) state_next = FINISH;
      end
      FINISH: begin
        complete   = 1'b1;
        state_next = IDLE;
      end
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt  <= '0;
      read_cnt  <= '0;
      cap_valid <= 1'b0;
      cap_idx   <= '0;
      for (int i = 0; i < N; i++) begin
        vec1[i]   <= '0;
        vec2[i]   <= '0;
        result[i] <= '0;
      end
    end else begin
      cap_valid <= acc_data_out_en;
      cap_idx   <= read_cnt[HSP_BANDS_WIDTH-1:0];
      if (cap_valid) result[cap_idx] <= acc_data_out;

      if (!busy && host_wr_en) begin
        if (host_wr_sel) vec2[host_wr_addr] <= host_wr_data;
        else             vec1[host_wr_addr] <= host_wr_data;
      end

      if (acc_data_in_en)   beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
      else if (state != SEND) beat_cnt <= '0;

      if (acc_data_out_en)     read_cnt <= read_cnt + 1'b1;
      else if (state != DRAIN) read_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_vctr_fifo_driver.sv
// Bench for vctr_fifo_driver: adder-style compute block model plus directed and random runs.
module tb_vctr_fifo_driver;

  localparam int WW = 16;
  localparam int HW = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          host_wr_en = 1'b0;
  logic          host_wr_sel = 1'b0;
  logic [HW-1:0] host_wr_addr = '0;
  logic [WW-1:0] host_wr_data = '0;
  logic [HW-1:0] host_rd_addr = '0;
  logic [WW-1:0] host_rd_data;
  logic          go = 1'b0;
  logic          busy, complete, error;
  logic          acc_start, acc_data_in_en, acc_data_out_en;
  logic [WW-1:0] acc_data_in;
  logic [WW-1:0] acc_data_out = '0;
  logic          acc_idle = 1'b1;
  logic          acc_ready = 1'b1;
  logic          acc_done = 1'b0;

  vctr_fifo_driver #(.WORD_WIDTH(WW), .HSP_BANDS_WIDTH(HW), .TIMEOUT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .host_wr_en(host_wr_en), .host_wr_sel(host_wr_sel), .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data), .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
    .go(go), .busy(busy), .complete(complete), .error(error),
    .acc_start(acc_start), .acc_data_in_en(acc_data_in_en), .acc_data_in(acc_data_in),
    .acc_data_out_en(acc_data_out_en), .acc_data_out(acc_data_out),
    .acc_idle(acc_idle), .acc_ready(acc_ready), .acc_done(acc_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // compute block model state
  logic [WW-1:0] beats[$];
  int strobe_cnt = 0;
  int gap_bad = 0;
  int stall_cycles = 0;
  int stall_left = 0;
  bit done_given = 1'b0;
  int stall_at = 0;
  bit hold_done = 1'b0;

  // expected vector contents as the host last wrote them
  logic [WW-1:0] e1 [N];
  logic [WW-1:0] e2 [N];

  function automatic logic [WW-1:0] sum_of(input int k);
    if (beats.size() >= k + N + 1) return beats[k] + beats[k+N];
    return '0;
  endfunction

  always begin : acc_model
    logic          nxt_ready, nxt_done;
    logic [WW-1:0] nxt_out;
    @(negedge clk);
    nxt_ready = acc_ready;
    nxt_done  = acc_done;
    nxt_out   = acc_data_out;
    if (acc_start) begin
      beats.delete();
      strobe_cnt = 0; gap_bad = 0; stall_cycles = 0; stall_left = 0;
      done_given = 1'b0; nxt_done = 1'b0; nxt_ready = 1'b1;
    end
    if (!acc_ready) stall_cycles++;
    if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) nxt_ready = 1'b1;
    end
    if (acc_data_in_en) begin
      if (!acc_ready) gap_bad++;
      beats.push_back(acc_data_in);
      if (beats.size() == stall_at) begin
        stall_left = 3;
        nxt_ready  = 1'b0;
      end
    end
    if (acc_data_out_en) begin
      nxt_out = sum_of(strobe_cnt);
      strobe_cnt++;
      nxt_done = 1'b0;
    end else if (!done_given && !hold_done && beats.size() == 2 * N) begin
      nxt_done   = 1'b1;
      done_given = 1'b1;
    end
    @(posedge clk);
    #1;
    acc_ready    = nxt_ready;
    acc_done     = nxt_done;
    acc_data_out = nxt_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vecs();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < N; i++) begin
        tick();
        host_wr_en   = 1'b1;
        host_wr_sel  = s[0];
        host_wr_addr = HW'(i);
        host_wr_data = (s == 0) ? e1[i] : e2[i];
      end
    end
    tick();
    host_wr_en = 1'b0;
  endtask

  task automatic pulse_go();
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int stall);
    int  n_complete = 0;
    bit  seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (complete) begin n_complete++; seen = 1'b1; end
    end
    check({tag, "_complete_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    for (int c = 0; c < 3; c++) begin
      if (complete) n_complete++;
      @(negedge clk);
    end
    check({tag, "_complete_count"}, n_complete, 1);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_beat_count"}, beats.size(), 2 * N);
    for (int i = 0; i < 2 * N && i < beats.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 32'(beats[i]), 32'(i < N ? e1[i] : e2[i-N]));
    check({tag, "_strobes"}, strobe_cnt, N);
    check({tag, "_gap_beats"}, gap_bad, 0);
    check({tag, "_stall_cycles"}, stall_cycles, (stall > 0) ? 3 : 0);
    for (int i = 0; i < N; i++) begin
      logic [WW-1:0] exp_sum;
      exp_sum = e1[i] + e2[i];
      host_rd_addr = HW'(i);
      #1;
      check($sformatf("%s_result%0d", tag, i), 32'(host_rd_data), 32'(exp_sum));
    end
    stall_at = 0;
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},       32'(busy), 32'd0);
    check({tag, "_complete"},   32'(complete), 32'd0);
    check({tag, "_error"},      32'(error), 32'd0);
    check({tag, "_acc_start"},  32'(acc_start), 32'd0);
    check({tag, "_in_en"},      32'(acc_data_in_en), 32'd0);
    check({tag, "_out_en"},     32'(acc_data_out_en), 32'd0);
    check({tag, "_data_in"},    32'(acc_data_in), 32'd0);
    check({tag, "_rd_data"},    32'(host_rd_data), 32'd0);
  endtask

  initial begin
    int n_en;
    tick(); tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // basic run
    for (int i = 0; i < N; i++) begin
      e1[i] = WW'(i + 1);
      e2[i] = WW'(10 * i);
    end
    load_vecs();
    pulse_go();
    finish_run("basic", 0);

    // stall after beat 5
    stall_at = 5;
    pulse_go();
    finish_run("stall", 5);

    // go while compute block busy
    acc_idle = 1'b0;
    pulse_go();
    repeat (3) tick();
    @(negedge clk);
    check("blocked_busy", 32'(busy), 32'd0);
    check("blocked_start", 32'(acc_start), 32'd0);
    tick();
    acc_idle = 1'b1;
    pulse_go();
    finish_run("unblocked", 0);

    // host write while busy is dropped
    pulse_go();
    for (int c = 0; c < 50 && beats.size() < 2; c++) tick();
    host_wr_en = 1'b1; host_wr_sel = 1'b0; host_wr_addr = '0; host_wr_data = 16'hFFFF;
    tick();
    host_wr_en = 1'b0;
    finish_run("busy_wr", 0);

    // write together with go lands and is used
    tick();
    host_wr_en = 1'b1; host_wr_sel = 1'b1; host_wr_addr = 3'd7; host_wr_data = 16'h1234;
    go = 1'b1;
    e2[7] = 16'h1234;
    tick();
    host_wr_en = 1'b0; go = 1'b0;
    finish_run("wr_go", 0);

    // reset in the middle of SEND
    pulse_go();
    n_en = 0;
    for (int c = 0; c < 100 && n_en < 9; c++) begin
      @(negedge clk);
      if (acc_data_in_en) n_en++;
    end
    check("rst_reached_beat9", n_en, 9);
    #1 rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      host_rd_addr = HW'(i);
      #1;
      check($sformatf("rst_cleared%0d", i), 32'(host_rd_data), 32'd0);
      e1[i] = '0;
      e2[i] = '0;
    end
    pulse_go();
    finish_run("after_rst", 0);

    // randomized vectors and stall point
    for (int r = 0; r < 3; r++) begin
      int st;
      for (int i = 0; i < N; i++) begin
        e1[i] = WW'($urandom);
        e2[i] = WW'($urandom);
      end
      st = int'($urandom_range(1, 2 * N - 1));
      load_vecs();
      stall_at = st;
      pulse_go();
      finish_run($sformatf("rand%0d", r), st);
    end

    // acc_done withheld
    hold_done = 1'b1;
    pulse_go();
    n_en = 0;
    for (int c = 0; c < 100 && n_en < 2 * N; c++) begin
      @(negedge clk);
      if (acc_data_in_en) n_en++;
    end
    check("hold_beats", n_en, 2 * N);
`ifdef VCTR_DRV_TIMEOUT_EN
    begin
      int n_c = 0;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        if (complete) n_c++;
      end
      check("wd_busy_at_15", 32'(busy), 32'd1);
      check("wd_error_at_15", 32'(error), 32'd0);
      @(negedge clk);
      if (complete) n_c++;
      check("wd_busy_after", 32'(busy), 32'd0);
      check("wd_error_after", 32'(error), 32'd1);
      check("wd_no_complete", n_c, 0);
      tick();
      hold_done = 1'b0;
      pulse_go();
      check("wd_error_cleared", 32'(error), 32'd0);
      finish_run("after_wd", 0);
    end
`else
    begin
      int n_c = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (complete) n_c++;
      end
      check("hold_still_busy", 32'(busy), 32'd1);
      check("hold_no_error", 32'(error), 32'd0);
      check("hold_no_complete", n_c, 0);
      check("hold_no_strobe", 32'(acc_data_out_en), 32'd0);
      tick();
      hold_done = 1'b0;
      finish_run("after_hold", 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vctr_fifo_driver.md
Name: vctr_fifo_driver

Overview:
- Master-side companion to the vector FIFO compute block.
- Holds two host-loaded input vectors of 2^HSP_BANDS_WIDTH words each.
- Runs the block's start/ready/done handshake, streams vector 1 then vector 2 into it, drains the result vector into a local result buffer, then signals completion to the host.
- Sits between a host register/bus adapter and the compute block.

Parameters:
- WORD_WIDTH, 16, width of every vector element and result word.
- HSP_BANDS_WIDTH, 3, log2 of vector length; N = 2^HSP_BANDS_WIDTH entries per vector.
- TIMEOUT_WIDTH, 16, width of the watchdog counter; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- host_wr_en  in  1  write one vector entry.
- host_wr_sel  in  1  0 = vector 1, 1 = vector 2.
- host_wr_addr  in  HSP_BANDS_WIDTH  entry index.
- host_wr_data  in  WORD_WIDTH  entry value.
- host_rd_addr  in  HSP_BANDS_WIDTH  result buffer index.
- host_rd_data  out  WORD_WIDTH  result[host_rd_addr], combinational read.
- go  in  1  request one run.
- busy  out  1  run in progress.
- complete  out  1  one-cycle pulse at end of a run.
- error  out  1  sticky timeout flag (optional feature).
- acc_start  out  1  start request to the compute block.
- acc_data_in_en  out  1  input beat valid.
- acc_data_in  out  WORD_WIDTH  input beat data.
- acc_data_out_en  out  1  result read strobe.
- acc_data_out  in  WORD_WIDTH  result word.
- acc_idle  in  1  compute block idle status.
- acc_ready  in  1  compute block ready status.
- acc_done  in  1  compute block done status.

Behaviour:
- Reset: state IDLE; all counters 0; vector and result buffers cleared to 0; every output 0.
- Clock and reset: single clock, asynchronous active-high reset.
- IDLE:
  - busy=0.
  - go=1 and acc_idle=1 -> START.
  - go while acc_idle=0 is ignored. It is not queued; the host must re-assert go.
- START:
  - acc_start=1 and busy=1.
  - Stays in START until acc_ready=1, then -> SEND. acc_start drops in SEND.
- SEND:
  - acc_data_in_en = acc_ready, combinational.
  - acc_data_in = beat counter b < N ? vec1[b] : vec2[b-N].
  - b increments on every cycle with acc_data_in_en=1.
  - acc_ready=0 stalls the stream with no beat and b held; streaming resumes with the same word.
  - After beat 2N-1 -> WAIT_DONE.
- WAIT_DONE: wait for acc_done=1 -> DRAIN.
- DRAIN:
  - acc_data_out_en=1 for exactly N consecutive cycles; read counter r runs 0..N-1.
  - acc_data_out is captured into result[k] one cycle after the k-th strobe.
  - Fixed read latency 1: the last capture happens the cycle after the last strobe.
  - After the last capture -> FINISH.
- FINISH: complete=1 for one cycle -> IDLE. busy falls in that same next cycle.
- Host writes:
  - Applied only when busy=0.
  - Writes while busy=1 are dropped.
  - Simultaneous host_wr_en and go in IDLE: the write lands and the run uses the new value.
- Host reads: allowed at any time; they return current result contents, which may be partially updated during DRAIN.
- Width rules: all data is passed through unmodified; counters are HSP_BANDS_WIDTH+1 bits, with no wrap inside a run.
- Reset mid-run: immediate abort to the reset state. acc_start, acc_data_in_en and acc_data_out_en drop asynchronously.

Optional Feature:
- Macro: VCTR_DRV_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_WIDTH-bit watchdog clears on entry to START and WAIT_DONE and counts each cycle spent in those states.
  - On reaching all-ones, the FSM -> IDLE and sets error=1, with no complete pulse.
  - error stays set until the next accepted go or reset.
- Not defined: no watchdog, error tied to 0, and START/WAIT_DONE wait indefinitely.

Test Plan:
1. Basic run (N=8): load vec1[i]=i+1 and vec2[i]=10*i, go with an adder model.
   - Required: 16 beats, in order 1..8 then 0,10,..,70.
   - Required: 8 strobes after done; result = 1,12,23,..,78.
   - Required: complete pulses once; busy=0 the next cycle.
2. Stall: drop acc_ready for 3 cycles after beat 5.
   - Required: no acc_data_in_en during the gap; the next beat carries 6; total beats = 16.
3. Go blocked: acc_idle=0 when go pulses.
   - Required: stays IDLE with busy=0 and acc_start=0.
   - Required: a later go with acc_idle=1 starts the run.
4. Write during busy: host_wr vec1[0]=0xFFFF in SEND.
   - Required: the write is ignored; the next run streams the old value 1.
5. Reset mid-SEND at beat 9.
   - Required: all outputs 0 immediately; a following run starts from beat 0 with buffers 0.
6. Timeout, macro defined, TIMEOUT_WIDTH=4: acc_done held 0.
   - Required: after 15 WAIT_DONE cycles, error=1, busy=0, no complete.
   - Required without the macro: remains in WAIT_DONE.
